unified_mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage).
- Grants one requester at a time; data wins ties, because the MEM-stage instruction is older.
- Generates per-port stall signals that hold the pipeline until each pending access has been served.
- Sits between the CPU top level and the external memory, replacing the separate ROM and RAM buses.

---
 rtl/unified_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Define MEM_ARB_TIMEOUT_EN to abort accesses whose ack never arrives.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              stall_if,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);
    typedef enum logic [1:0] { IDLE, DATA, INST } state_t;

    state_t            state;
    state_t            state_nx;
    logic              d_req;
    logic              adv;
    logic              grant_d;
    logic              grant_i;
    logic              done;
    logic              done_d;
    logic              done_i;
    logic              abort;
    logic              i_srv;
    logic              d_srv;
    logic [DATA_W-1:0] rdata_nx;

    assign d_req     = d_re | d_we;
    assign stall_mem = d_req & ~d_srv;
    assign stall_if  = i_ce & ~i_srv;
    assign adv       = ~stall_if & ~stall_mem;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Abort on the edge where the wait count would reach TIMEOUT.
    assign abort = (state != IDLE) & ~mem_ack &
                   (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            if (grant_d | grant_i)
                cnt <= '0;
            else if (state != IDLE && !mem_ack)
                cnt <= cnt + 1'b1;
            if (abort)
                bus_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (stall_mem) begin
                    grant_d  = 1'b1;
                    state_nx = DATA;
                end else if (stall_if) begin
                    grant_i  = 1'b1;
                    state_nx = INST;
                end
            end
            DATA, INST: begin
                if (mem_ack | abort) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign done_d   = done & (state == DATA);
    assign done_i   = done & (state == INST);
    assign rdata_nx = abort ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= 4'h0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_srv     <= 1'b0;
            d_srv     <= 1'b0;
        end else begin
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_sel   <= d_sel;
            end else if (grant_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= i_addr;
                mem_sel  <= 4'hF;
            end else if (done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            // Served flags outlive the access until the whole pipeline advances.
            if (done_d) begin
                d_srv <= 1'b1;
                if (!mem_we || abort)
                    d_rdata <= rdata_nx;
            end else if (adv) begin
                d_srv <= 1'b0;
            end

            if (done_i) begin
                i_srv   <= 1'b1;
                i_rdata <= rdata_nx;
            end else if (adv) begin
                i_srv <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter, checked against a transaction-level
// model of the access order, stall lengths and returned data.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int TMO = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ce;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        stall_if;
    logic        d_re;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    acc_t        exp_q [$];
    acc_t        seen_q[$];
    int          lat_q [$];
    logic [31:0] exp_ird = 32'h0;
    logic [31:0] exp_drd = 32'h0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_ce     (i_ce),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .stall_if (stall_if),
        .d_re     (d_re),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_sel    (d_sel),
        .d_rdata  (d_rdata),
        .stall_mem(stall_mem),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_sel  (mem_sel),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void model_fetch(input logic [31:0] a);
        exp_ird = ref_rd(a);
    endfunction

    function automatic void model_data(input acc_t a, input bit to);
        if (to) begin
            exp_drd = 32'h0;
            exp_err = 1'b1;
        end else if (a.we) begin
            ref_mem[a.addr] = merge(ref_rd(a.addr), a.wdata, a.sel);
        end else begin
            exp_drd = ref_rd(a.addr);
        end
    endfunction

    // External memory: acks each access after its queued latency.
    bit   busy = 1'b0;
    int   wcnt = 0;
    int   cur_lat = 0;
    acc_t cur;
    always @(negedge clk) begin
        int idx;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!rst || !mem_req) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wcnt      = 0;
                cur.we    = mem_we;
                cur.addr  = mem_addr;
                cur.sel   = mem_sel;
                cur.wdata = mem_wdata;
                seen_q.push_back(cur);
                cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end else begin
                idx = seen_q.size() - 1;
                if (idx < exp_q.size())
                    check("req_hold_addr", mem_addr, exp_q[idx].addr);
            end
            if (wcnt == cur_lat) begin
                mem_ack = 1'b1;
                if (cur.we)
                    phys_mem[cur.addr] = merge(phys_rd(cur.addr), cur.wdata, cur.sel);
                else
                    mem_rdata = phys_rd(cur.addr);
                busy = 1'b0;
            end
            wcnt++;
        end
    end

    task automatic idle_inputs();
        i_ce    = 1'b0;
        d_re    = 1'b0;
        d_we    = 1'b0;
        i_addr  = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_sel   = 4'($urandom);
    endtask

    // One pipeline step: optional fetch and data access, held until advance.
    // dd > 0 raises the data request dd cycles after the fetch starts.
    task automatic step(input bit do_i, input logic [31:0] ia, input bit do_d,
                        input bit re, input bit we, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input int li, input int ld, input int dd,
                        input bit d_to);
        acc_t ai, ad;
        int   ld_t, t, e_si, e_sm, cyc, si, sm, n;
        bit   ffirst, fin;
        ai.we = 1'b0; ai.addr = ia; ai.sel = 4'hF; ai.wdata = 32'h0;
        ad.we = we;   ad.addr = da; ad.sel = sel;  ad.wdata = wd;
        ld_t   = d_to ? TMO - 1 : ld;
        ffirst = do_i && do_d && dd > 0;
        exp_q.delete();
        if (ffirst) begin
            exp_q.push_back(ai); lat_q.push_back(li); model_fetch(ia);
            exp_q.push_back(ad); lat_q.push_back(d_to ? 1000 : ld);
            model_data(ad, d_to);
        end else begin
            if (do_d) begin
                exp_q.push_back(ad); lat_q.push_back(d_to ? 1000 : ld);
                model_data(ad, d_to);
            end
            if (do_i) begin
                exp_q.push_back(ai); lat_q.push_back(li); model_fetch(ia);
            end
        end
        t    = (do_d ? ld_t + 2 : 0) + (do_i ? li + 2 : 0);
        e_si = ffirst ? li + 2 : (do_i ? t : 0);
        e_sm = ffirst ? t - dd : (do_d ? ld_t + 2 : 0);

        i_ce   = do_i;
        i_addr = ia;
        cyc = 0; si = 0; sm = 0; fin = 1'b0;
        while (!fin && cyc <= t + 20) begin
            if (do_d && cyc == dd) begin
                d_re = re; d_we = we; d_addr = da; d_wdata = wd; d_sel = sel;
            end
            @(negedge clk);
            if (stall_if)  si++;
            if (stall_mem) sm++;
            if (!stall_if && !stall_mem && (!do_d || cyc >= dd)) begin
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        check("adv_cycle", cyc, t);
        check("stall_if_cycles", si, e_si);
        check("stall_mem_cycles", sm, e_sm);
        check("i_rdata", i_rdata, exp_ird);
        check("d_rdata", d_rdata, exp_drd);
        check("bus_err", bus_err, exp_err);
        check("grants", seen_q.size(), exp_q.size());
        n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check("grant_addr", seen_q[k].addr, exp_q[k].addr);
            check("grant_we", seen_q[k].we, exp_q[k].we);
            check("grant_sel", seen_q[k].sel, exp_q[k].sel);
            if (exp_q[k].we)
                check("grant_wdata", seen_q[k].wdata, exp_q[k].wdata);
        end
        seen_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] ia, da;
        int          li, ld, dd, k;
        bit          di, dq;

        rst = 1'b0;
        idle_inputs();
        phys_mem[32'h100] = 32'h2402_0005;
        ref_mem[32'h100]  = 32'h2402_0005;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_sel", mem_sel, 4'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_stall_mem", stall_mem, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        step(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
        step(1, 32'h104, 1, 1, 0, 32'h200, 32'h0, 4'hF, 3, 3, 0, 0);
        step(1, 32'h108, 1, 0, 1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1, 2, 0, 0);
        step(1, 32'h10C, 1, 1, 0, 32'h40, 32'h0, 4'hF, 2, 3, 1, 0);

        d_re   = 1'b1;
        d_addr = 32'h80;
        d_sel  = 4'hF;
        exp_q.delete();
        lat_q.push_back(50);
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_req", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_sel", mem_sel, 4'h0);
        check("abort_i_rdata", i_rdata, 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_stall_mem", stall_mem, 1'b1);
        exp_ird = 32'h0;
        exp_drd = 32'h0;
        exp_err = 1'b0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        seen_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        step(1, 32'h100, 1, 1, 0, 32'h40, 32'h0, 4'hF, 1, 0, 0, 0);

        for (int s = 0; s < 200; s++) begin
            di = ($urandom_range(0, 3) != 0);
            dq = ($urandom_range(0, 1) != 0);
            ia = 32'($urandom_range(0, 63)) << 2;
            da = 32'($urandom_range(0, 63)) << 2;
            li = $urandom_range(0, 4);
            ld = $urandom_range(0, 4);
            k  = $urandom_range(0, 2);
            dd = 0;
            if (di && dq && $urandom_range(0, 3) == 0)
                dd = $urandom_range(1, li + 1);
            step(di, ia, dq, k != 1, k != 0, da, $urandom, 4'($urandom),
                 li, ld, dd, 0);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        step(0, 32'h0, 1, 1, 0, 32'h300, 32'h0, 4'hF, 0, 0, 0, 1);
        step(1, 32'h104, 1, 1, 0, 32'h44, 32'h0, 4'hF, 1, 1, 0, 0);
`endif

        repeat (6) @(posedge clk);
        #1;
        check("idle_grants", seen_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
